// File: rtl/sequenciador_exibicao_if.sv
// Control handshake and RAM/LED bus of the sequence playback controller.
// The master modport is the control unit / datapath side; slave is the sequencer.
interface sequenciador_exibicao_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
);
    logic              inicia;
    logic              cancela;
    logic [ADDR_W-1:0] limite;
    logic [DATA_W-1:0] dado_mem;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              fim;
    logic [2:0]        db_estado;

    modport master (
        output inicia, cancela, limite, dado_mem,
        input  endereco, leds, ocupado, fim, db_estado
    );

    modport slave (
        input  inicia, cancela, limite, dado_mem,
        output endereco, leds, ocupado, fim, db_estado
    );
endinterface

// File: rtl/sequenciador_exibicao.sv
// Plays back sequence RAM addresses 0..limite on the LEDs: each play lit for T_ON cycles,
// then dark for T_OFF cycles; pulses fim when the last play has been shown.
module sequenciador_exibicao #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned T_ON   = 1000,
    parameter int unsigned T_OFF  = 500
) (
    input logic                    clock,
    input logic                    reset_n,
    sequenciador_exibicao_if.slave bus
);
    localparam int unsigned TMax = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

    typedef enum logic [2:0] {
        Ocioso  = 3'd0,
        Carrega = 3'd1,
        Acende  = 3'd2,
        Apaga   = 3'd3,
        Avanca  = 3'd4,
        Fim     = 3'd5
    } estado_t;

    estado_t           estado;
    logic [ADDR_W-1:0] contador;
    logic [ADDR_W-1:0] limiteReg;
    logic [DATA_W-1:0] ledsReg;
    logic [TW-1:0]     timer;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= Ocioso;
            contador  <= '0;
            limiteReg <= '0;
            ledsReg   <= '0;
            timer     <= '0;
        end else if (bus.cancela && (estado != Ocioso)) begin
            // Abort beats every transition; leds go dark because they decode from state.
            estado <= Ocioso;
            timer  <= '0;
        end else begin
            case (estado)
                Ocioso: begin
                    if (bus.inicia && !bus.cancela) begin
                        estado    <= Carrega;
                        limiteReg <= bus.limite;
                        contador  <= '0;
                        timer     <= '0;
                    end
                end
                Carrega: begin
                    ledsReg <= bus.dado_mem;
                    estado  <= Acende;
                end
                Acende: begin
                    if (timer == TW'(T_ON - 1)) begin
                        timer  <= '0;
                        estado <= Apaga;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                Apaga: begin
                    if (timer == TW'(T_OFF - 1)) begin
                        timer <= '0;
                        // End test precedes the increment so limite = all-ones never wraps.
                        estado <= (contador == limiteReg) ? Fim : Avanca;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                Avanca: begin
                    contador <= contador + ADDR_W'(1);
                    estado   <= Carrega;
                end
                Fim:     estado <= Ocioso;
                default: estado <= Ocioso;
            endcase
        end
    end

    assign bus.endereco  = contador;
    assign bus.leds      = (estado == Acende) ? ledsReg : '0;
    assign bus.ocupado   = (estado != Ocioso);
    assign bus.fim       = (estado == Fim);
    assign bus.db_estado = estado;
endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Directed bench for sequenciador_exibicao with T_ON=4, T_OFF=2 (8 cycles per play).
// Cycle Ek is the clock period ending at edge Ek; inicia is sampled at E0.
module tb_sequenciador_exibicao;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] ram [16];
    int compared = 0;
    int mismatched = 0;

    sequenciador_exibicao_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    sequenciador_exibicao #(
        .ADDR_W(4),
        .DATA_W(4),
        .T_ON  (4),
        .T_OFF (2)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    assign bus.dado_mem = ram[bus.endereco];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and sit at its falling edge.
    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic start(input logic [3:0] lim);
        bus.limite = lim;
        bus.inicia = 1'b1;
        next_cycle();
        bus.inicia = 1'b0;
    endtask

    initial begin
        bus.inicia  = 1'b0;
        bus.cancela = 1'b0;
        bus.limite  = '0;
        for (int i = 0; i < 16; i++) ram[i] = 4'(i);

        // Reset state
        #12;
        check("rst leds", 32'(bus.leds), 0);
        check("rst ocupado", 32'(bus.ocupado), 0);
        check("rst fim", 32'(bus.fim), 0);
        check("rst endereco", 32'(bus.endereco), 0);
        check("rst estado", 32'(bus.db_estado), 0);
        @(negedge clock);
        reset_n = 1'b1;
        next_cycle();

        // Test 1 (+ ignored inicia pulses and limite change mid-run)
        ram[0] = 4'd1; ram[1] = 4'd2; ram[2] = 4'd4;
        start(4'd2);
        for (int c = 1; c <= 26; c++) begin
            bus.inicia = (c == 3 || c == 12);
            if (c >= 2) bus.limite = 4'd0;
            check($sformatf("t1 leds c%0d", c), 32'(bus.leds),
                  (c >= 2 && c <= 5) ? 1 : (c >= 10 && c <= 13) ? 2 :
                  (c >= 18 && c <= 21) ? 4 : 0);
            check($sformatf("t1 fim c%0d", c), 32'(bus.fim), (c == 24) ? 1 : 0);
            check($sformatf("t1 ocupado c%0d", c), 32'(bus.ocupado), (c <= 24) ? 1 : 0);
            if (c == 1) check("t1 estado carrega", 32'(bus.db_estado), 1);
            if (c == 7) check("t1 estado apaga", 32'(bus.db_estado), 3);
            if (c == 8) check("t1 estado avanca", 32'(bus.db_estado), 4);
            if (c == 9) check("t1 endereco c9", 32'(bus.endereco), 1);
            if (c == 24) check("t1 estado fim", 32'(bus.db_estado), 5);
            next_cycle();
        end
        bus.inicia = 1'b0;

        // Test 2: limite=0, single play of 8; fim at E0+1+8-1 = E8
        ram[0] = 4'd8;
        start(4'd0);
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("t2 leds c%0d", c), 32'(bus.leds), (c >= 2 && c <= 5) ? 8 : 0);
            check($sformatf("t2 fim c%0d", c), 32'(bus.fim), (c == 8) ? 1 : 0);
            check($sformatf("t2 endereco c%0d", c), 32'(bus.endereco), 0);
            next_cycle();
        end

        // Test 3: limite=15, RAM[i]=i, no wrap, fim at E128
        for (int i = 0; i < 16; i++) ram[i] = 4'(i);
        start(4'd15);
        for (int c = 1; c <= 130; c++) begin
            int p, ph;
            p  = (c <= 128) ? (c - 1) / 8 : 15;
            ph = (c - 1) % 8;
            check($sformatf("t3 endereco c%0d", c), 32'(bus.endereco), 32'(p));
            check($sformatf("t3 leds c%0d", c), 32'(bus.leds),
                  (c <= 128 && ph >= 1 && ph <= 4) ? 32'(p) : 0);
            check($sformatf("t3 fim c%0d", c), 32'(bus.fim), (c == 128) ? 1 : 0);
            next_cycle();
        end

        // Test 4: cancela during the 2nd ACENDE, then restart from address 0
        ram[0] = 4'd1; ram[1] = 4'd2; ram[2] = 4'd4;
        start(4'd2);
        for (int c = 1; c < 11; c++) next_cycle();
        check("t4 leds before cancel", 32'(bus.leds), 2);
        bus.cancela = 1'b1;
        next_cycle();
        bus.cancela = 1'b0;
        check("t4 estado", 32'(bus.db_estado), 0);
        check("t4 leds", 32'(bus.leds), 0);
        check("t4 ocupado", 32'(bus.ocupado), 0);
        for (int c = 0; c < 16; c++) begin
            check($sformatf("t4 no fim %0d", c), 32'(bus.fim), 0);
            next_cycle();
        end
        start(4'd2);
        check("t4 restart endereco", 32'(bus.endereco), 0);
        check("t4 restart estado", 32'(bus.db_estado), 1);
        next_cycle();
        check("t4 restart leds", 32'(bus.leds), 1);

        // Test 5: asynchronous reset during APAGA (cycle 6)
        for (int c = 2; c < 6; c++) next_cycle();
        check("t5 estado apaga", 32'(bus.db_estado), 3);
        reset_n = 1'b0;
        #1;
        check("t5 estado", 32'(bus.db_estado), 0);
        check("t5 ocupado", 32'(bus.ocupado), 0);
        check("t5 endereco", 32'(bus.endereco), 0);
        check("t5 leds", 32'(bus.leds), 0);
        check("t5 fim", 32'(bus.fim), 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check($sformatf("t5 no fim %0d", c), 32'(bus.fim), 0);
            next_cycle();
        end

        // Test 6: inicia and cancela together in OCIOSO
        bus.inicia  = 1'b1;
        bus.cancela = 1'b1;
        next_cycle();
        check("t6 estado", 32'(bus.db_estado), 0);
        check("t6 ocupado", 32'(bus.ocupado), 0);
        bus.inicia  = 1'b0;
        bus.cancela = 1'b0;
        next_cycle();
        check("t6 estado after", 32'(bus.db_estado), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
